// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI controller and its peripheral counterpart:
//   - spi_state_t : controller frame sequencer states
//   - SPI_TX_BITS / SPI_RX_BITS : default word widths (16/16)
//   - max3()      : helper used to size the shared CS timer
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int SPI_TX_BITS = 16;
    localparam int SPI_RX_BITS = 16;

    // Largest of three integers; sizes a timer that serves several phases.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// SCK generator: CLK_DIV clk cycles per SCK half-period, running only while
// en is high. The first rising edge comes on the first enabled clk edge.
// Ports:
//   clk, rst     system clock / async active-high reset
//   en           run enable (high only while the frame is in XFER)
//   last         all rising edges of the frame issued; suppress further rises
//   sck          registered serial clock, idles low
//   sck_rise     high in the clk cycle whose edge drives SCK high
//   sck_fall     high in the clk cycle whose edge drives SCK low
//   period_done  high when the final low half-period has fully elapsed
// ---------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic last,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic period_done
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_clk_gen: CLK_DIV must be at least 2");
    end

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             edge_due;

    // Strobes are decoded from registered state, so they announce the edge
    // at which sck toggles; a stale half-period can never leak through.
    assign edge_due    = en && (div_cnt == '0);
    assign sck_rise    = edge_due && !sck && !last;
    assign sck_fall    = edge_due && sck;
    assign period_done = edge_due && !sck && last;

    // Divider and SCK register; dropping en returns both to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (sck_rise || sck_fall) begin
            div_cnt <= DIV_RELOAD;
            sck     <= !sck;
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
        end else begin
            div_cnt <= div_cnt;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
// Mode-0 SPI controller. One frame = TX_BITS write bits (LSB first), RX_SKIP
// turnaround SCK periods, then RX_BITS read bits (LSB first), in one CS-low
// window framed by CS_SETUP / CS_HOLD / CS_IDLE clk-cycle guards.
// Ports:
//   clk, rst  system clock / async active-high reset
//   start     frame request, taken only while busy is low
//   tx_data   write word, captured when start is taken
//   busy      frame in progress (through the CS idle gap)
//   done      one-cycle pulse when rx_data is updated
//   rx_data   last received word
//   SCK, COPI, CS  serial outputs (all registered); CIPO serial input
// ---------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int TX_BITS  = SPI_TX_BITS,
    parameter int RX_BITS  = SPI_RX_BITS,
    parameter int RX_SKIP  = 1,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TX_BITS-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [RX_BITS-1:0] rx_data,
    output logic               SCK,
    output logic               COPI,
    input  logic               CIPO,
    output logic               CS
);

    localparam int N_SCK = TX_BITS + RX_SKIP + RX_BITS;
    localparam int BIT_W = $clog2(N_SCK + 1);
    localparam int TMR_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(N_SCK);
    localparam logic [BIT_W-1:0] BIT_TX_END   = BIT_W'(TX_BITS);
    localparam logic [BIT_W-1:0] BIT_RX_FIRST = BIT_W'(TX_BITS + RX_SKIP);
    localparam logic [TMR_W-1:0] SETUP_LAST   = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] IDLE_LAST    = TMR_W'(CS_IDLE - 1);

    spi_state_t         state;
    logic [TX_BITS-2:0] tx_shift;   // bits 1.. of the write word; bit 0 goes out in SETUP
    logic [RX_BITS-1:0] rx_shift;
    logic [BIT_W-1:0]   bit_cnt;    // SCK rising edges issued so far this frame
    logic [TMR_W-1:0]   tmr;        // shared SETUP / HOLD / GAP cycle timer
    logic               xfer_en;
    logic               last_bit;
    logic               sck_rise;
    logic               sck_fall;
    logic               period_done;

    assign xfer_en  = (state == XFER);
    assign last_bit = (bit_cnt == BIT_LAST);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (xfer_en),
        .last        (last_bit),
        .sck         (SCK),
        .sck_rise    (sck_rise),
        .sck_fall    (sck_fall),
        .period_done (period_done)
    );

    // Frame sequencer with its shift registers, bit counter and CS timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            CS       <= 1'b1;
            COPI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            tmr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        CS       <= 1'b0;
                        busy     <= 1'b1;
                        COPI     <= tx_data[0];
                        tx_shift <= tx_data[TX_BITS-1:1];
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        tmr      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    if (tmr == SETUP_LAST) begin
                        state <= XFER;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                XFER: begin
                    // bit_cnt still holds k-1 in the cycle of rising edge k.
                    if (sck_rise) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt >= BIT_RX_FIRST) begin
                            rx_shift <= {CIPO, rx_shift[RX_BITS-1:1]};
                        end else begin
                            rx_shift <= rx_shift;
                        end
                    end else begin
                        bit_cnt <= bit_cnt;
                    end
                    // On the fall after rising edge k, present write bit k.
                    if (sck_fall) begin
                        tx_shift <= tx_shift >> 1;
                        COPI     <= (bit_cnt < BIT_TX_END) ? tx_shift[0] : 1'b0;
                    end else begin
                        tx_shift <= tx_shift;
                    end
                    if (period_done) begin
                        state <= HOLD;
                        tmr   <= '0;
                    end else begin
                        state <= XFER;
                    end
                end
                HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        state   <= GAP;
                        CS      <= 1'b1;
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr == IDLE_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    CS    <= 1'b1;
                    COPI  <= 1'b0;
                    busy  <= 1'b0;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
// Self-checking bench: a cycle-timeline model of the frame (derived from the
// frame arithmetic, not from the FSM) is compared against every DUT output on
// every clk cycle; a behavioural SPI peripheral drives CIPO and captures COPI.
// A second instance with fast timing checks the short-frame latency.
// ---------------------------------------------------------------------------
module tb_spi_controller;

    localparam int TXB  = 16;
    localparam int RXB  = 16;
    localparam int SKIP = 1;
    localparam int DIV  = 4;
    localparam int CSS  = 2;
    localparam int CSH  = 2;
    localparam int CSI  = 2;
    localparam int NB   = TXB + SKIP + RXB;       // SCK periods per frame
    localparam int S    = 1 + CSS;                // first SCK rise, cycles after acceptance
    localparam int L    = S + 2 * DIV * NB + CSH; // done / CS rise, cycles after acceptance

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        busy, done, SCK, COPI, CIPO, CS;
    logic [15:0] rx_data;

    logic        start2 = 1'b0;
    logic [15:0] tx2 = 16'h0000;
    logic        busy2, done2, SCK2, COPI2, CS2;
    logic [15:0] rx2;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_controller dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .SCK(SCK), .COPI(COPI), .CIPO(CIPO), .CS(CS)
    );

    spi_controller #(
        .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .busy(busy2), .done(done2), .rx_data(rx2),
        .SCK(SCK2), .COPI(COPI2), .CIPO(COPI2), .CS(CS2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural peripheral ----------------
    logic        loopback = 1'b0;
    logic [15:0] data_send = 16'h0000;
    logic        per_cipo = 1'b1;
    int          per_rises = 0;
    int          sck_pulses = 0;
    logic [15:0] per_copi_reg = 16'h0000;
    logic        sck_q = 1'b0;
    logic        cs_q = 1'b1;

    assign CIPO = loopback ? COPI : per_cipo;

    always @(SCK or CS) begin
        if (CS === 1'b0 && cs_q === 1'b1) begin
            per_rises = 0; sck_pulses = 0; per_copi_reg = 16'h0000; per_cipo = 1'b1;
        end
        if (SCK === 1'b1 && sck_q === 1'b0) begin
            per_rises++; sck_pulses++;
            if (per_rises <= TXB) per_copi_reg[per_rises-1] = COPI;
        end
        if (SCK === 1'b0 && sck_q === 1'b1) begin
            if (per_rises >= TXB + SKIP && per_rises < NB) per_cipo = data_send[per_rises-TXB-SKIP];
            else per_cipo = 1'b1;
        end
        sck_q = SCK; cs_q = CS;
    end

    int sck2_cnt = 0;
    always @(posedge SCK2) sck2_cnt++;

    // ---------------- timeline model ----------------
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_rel = 0;
    int          m_acc = 0;
    logic [15:0] m_tx = 16'h0000;
    logic [15:0] m_rx = 16'h0000;
    logic [15:0] m_rx_new = 16'h0000;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_act = 1'b0; m_rel = 0; m_rx = 16'h0000;
        end else if (m_act) begin
            m_rel++;
            if (m_rel == L) m_rx = m_rx_new;
            if (m_rel == L + CSI) m_act = 1'b0;
        end else if (start) begin
            m_act = 1'b1; m_rel = 0; m_acc = cyc; m_tx = tx_data;
            m_rx_new = loopback ? 16'h0000 : data_send;
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt = 0;
    int last_lat = 0;
    int cs_hi_run = 0;
    int gaps[$];
    logic e_cs, e_sck, e_copi, e_busy, e_done;
    logic [15:0] e_rx;
    int r, k;

    always @(negedge clk) begin
        if (chk_en) begin
            e_cs = 1'b1; e_sck = 1'b0; e_copi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rx = m_rx;
            if (rst) begin
                e_rx = 16'h0000;
            end else if (m_act) begin
                r = m_rel;
                e_busy = 1'b1;
                e_cs = (r < L) ? 1'b0 : 1'b1;
                e_done = (r == L);
                if (r >= S && r < S + 2 * DIV * NB) e_sck = (((r - S) % (2 * DIV)) < DIV);
                if (r < S + DIV) k = 0;
                else if (r >= S + 2 * DIV * NB) k = NB;
                else k = (r - S - DIV) / (2 * DIV) + 1;
                e_copi = (k < TXB) ? m_tx[k] : 1'b0;
            end
            chk("cs", CS, e_cs);
            chk("sck", SCK, e_sck);
            chk("copi", COPI, e_copi);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("rx_data", rx_data, e_rx);
            if (done === 1'b1) begin done_cnt++; last_lat = cyc - m_acc; end
            if (!rst) begin
                if (CS === 1'b1) cs_hi_run++;
                else begin
                    if (cs_hi_run > 0) gaps.push_back(cs_hi_run);
                    cs_hi_run = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        if (n >= budget) chk("idle_timeout", busy, 0);
    endtask

    task automatic send(input logic [15:0] w);
        tx_data = w; start = 1'b1;
        tick();
        start = 1'b0; tx_data = 16'($urandom);
    endtask

    int seq[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        int d0, g0, n;
        #1 rst = 1'b1; chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_cs", CS, 1); chk("rst_sck", SCK, 0); chk("rst_copi", COPI, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rx", rx_data, 16'h0000);
        rst = 1'b0;
        repeat (2) tick();

        // peripheral frame: BEEF out, 1234 back, one done, 269-cycle latency
        loopback = 1'b0; data_send = 16'h1234; d0 = done_cnt;
        send(16'hBEEF);
        wait_idle(1000);
        chk("per_copi_reg", per_copi_reg, 16'hBEEF);
        chk("rx_1234", rx_data, 16'h1234);
        chk("done_once", done_cnt - d0, 1);
        chk("latency", last_lat, 269);

        // loopback A5C3: bit order, 33 pulses, rx 0
        loopback = 1'b1;
        send(16'hA5C3);
        wait_idle(1000);
        for (int i = 0; i < 16; i++) chk($sformatf("copi_bit%0d", i), per_copi_reg[i], seq[i]);
        chk("sck_pulses", sck_pulses, 33);
        chk("rx_loopback", rx_data, 16'h0000);

        // start while busy is ignored
        loopback = 1'b0; data_send = 16'h9A6C; d0 = done_cnt;
        send(16'h0F0F);
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (100) tick();
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        wait_idle(1000);
        repeat (5) tick();
        chk("busy_ignored_done", done_cnt - d0, 1);
        chk("rx_9a6c", rx_data, 16'h9A6C);

        // start held high: back-to-back frames
        g0 = gaps.size(); d0 = done_cnt; n = 0;
        tx_data = 16'h3C5A; start = 1'b1;
        while (done_cnt - d0 < 3 && n < 2000) begin tick(); n++; end
        start = 1'b0;
        wait_idle(1000);
        chk("held_frames", done_cnt - d0, 3);
        chk("held_gaps_seen", (gaps.size() - g0 >= 2), 1);
        for (int i = g0; i < gaps.size(); i++) chk("cs_idle_gap", (gaps[i] >= CSI), 1);

        // reset at rising edge 10
        data_send = 16'h5A3C; d0 = done_cnt; n = 0;
        send(16'h1357);
        while (m_rel != S + 2 * DIV * 9 && n < 400) begin tick(); n++; end
        chk("sck_at_rise10", SCK, 1);
        rst = 1'b1;
        #1;
        chk("abort_cs", CS, 1); chk("abort_sck", SCK, 0);
        chk("abort_rx", rx_data, 16'h0000); chk("abort_busy", busy, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        send(16'h2468);
        wait_idle(1000);
        chk("after_abort_rx", rx_data, 16'h5A3C);
        chk("after_abort_copi", per_copi_reg, 16'h2468);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            loopback = 1'($urandom_range(0, 1));
            data_send = 16'($urandom);
            repeat ($urandom_range(0, 4)) tick();
            send(16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 300)) tick();
                start = 1'b1; tick(); start = 1'b0;
            end
            wait_idle(1000);
        end

        // fast-timing instance: 135-cycle latency, 33 pulses
        tx2 = 16'hC0DE; start2 = 1'b1;
        tick();
        start2 = 1'b0; n = 0;
        while (done2 !== 1'b1 && n < 400) begin tick(); n++; end
        chk("fast_latency", n, 135);
        chk("fast_pulses", sck2_cnt, 33);
        chk("fast_rx", rx2, 16'h0000);
        repeat (3) tick();
        chk("fast_idle", busy2, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
